// File: rtl/ks_sum_stage.sv
// ks_sum_stage
// -----------------------------------------------------------------------------
// Final registered stage of a 16-bit Kogge-Stone adder. It turns the completed
// group-generate vector and the saved propagate bits into the sum, carry-out
// and signed overflow. Signed saturation is optional. The result is held in a
// two-entry skid buffer, so the downstream datapath can stall without losing
// operands.
//
// Parameters
//   SAT_EN    1: saturate on signed overflow when i_sat is set; 0: i_sat ignored
//
// Ports
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_valid   upstream word valid
//   o_ready   stage can accept a word (registered)
//   i_c0      adder carry-in
//   i_gk      completed prefix generates, i_gk[k] = carry out of bit k
//   i_p_save  bitwise propagate a^b
//   i_sat     saturate this word on signed overflow
//   o_valid   result valid
//   i_ready   downstream accepts result
//   o_sum     16-bit result (possibly saturated)
//   o_cout    raw unsigned carry-out
//   o_ovf     raw signed overflow of the unsaturated sum
// -----------------------------------------------------------------------------
module ks_sum_stage #(
    parameter int SAT_EN = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_c0,
    input  logic [15:0] i_gk,
    input  logic [15:0] i_p_save,
    input  logic        i_sat,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [15:0] o_sum,
    output logic        o_cout,
    output logic        o_ovf
);

    localparam bit SAT_ON = (SAT_EN != 0);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } word_t;

    state_t state_q, state_d;
    word_t  out_q,   out_d;
    word_t  skid_q,  skid_d;
    logic   ready_q, ready_d;

    word_t  new_word;
    logic   acc;
    logic   rel;

    // -------------------------------------------------------------------------
    // Sum formation. The carry into bit k is the group generate of bits k-1..0
    // (which already folds in c0), so the carry vector is i_gk shifted up by
    // one with c0 entering at bit 0.
    // -------------------------------------------------------------------------
    always_comb begin
        logic [15:0] raw_sum;
        logic        raw_cout;
        logic        raw_ovf;

        raw_sum  = i_p_save ^ {i_gk[14:0], i_c0};
        raw_cout = i_gk[15];
        // Carry into the sign bit differs from carry out of it.
        raw_ovf  = i_gk[15] ^ i_gk[14];

        new_word.sum  = raw_sum;
        new_word.cout = raw_cout;
        new_word.ovf  = raw_ovf;

        // On overflow both operands share a sign; a carry out of the sign bit
        // means both were negative, so clamp to the most negative value.
        if (SAT_ON && i_sat && raw_ovf) begin
            new_word.sum = raw_cout ? 16'h8000 : 16'h7FFF;
        end
    end

    assign acc = i_valid & ready_q;
    assign rel = o_valid & i_ready;

    // -------------------------------------------------------------------------
    // Skid-buffer control.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so a path that
        // forgets to assign it holds the register value instead of inferring a latch.
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    out_d   = new_word;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (acc && !rel) begin
                    skid_d  = new_word;
                    state_d = ST_TWO;
                end else if (acc && rel) begin
                    out_d = new_word;
                end else if (rel) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // o_ready is low here, so no new word can arrive.
                if (rel) begin
                    out_d   = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Ready is registered from the next state, which keeps any
        // combinational path from i_ready to o_ready out of the design.
        ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: sequential state uses non-blocking assignments only, so every
            // flop samples its pre-edge inputs regardless of statement order.
            state_q <= ST_EMPTY;
            ready_q <= 1'b1;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign o_ready = ready_q;
    assign o_valid = (state_q != ST_EMPTY);
    assign o_sum   = out_q.sum;
    assign o_cout  = out_q.cout;
    assign o_ovf   = out_q.ovf;

endmodule

// File: tb/tb_ks_sum_stage.sv
// tb_ks_sum_stage
// -----------------------------------------------------------------------------
// Self-checking bench for ks_sum_stage. A behavioural ripple-carry model turns
// operands a, b and c0 into i_gk/i_p_save. Expected results are computed with
// plain integer addition and pushed onto a scoreboard queue when a word is
// accepted. They are popped and compared when the stage releases a word.
// A second instance with SAT_EN=0 receives the same stimulus, and its sum is
// checked against the unsaturated result.
// -----------------------------------------------------------------------------
module tb_ks_sum_stage;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        i_c0;
    logic [15:0] i_gk;
    logic [15:0] i_p_save;
    logic        i_sat;
    logic        i_ready;

    logic        o_ready,    o_valid,    o_cout,    o_ovf;
    logic [15:0] o_sum;
    logic        ns_o_ready, ns_o_valid, ns_o_cout, ns_o_ovf;
    logic [15:0] ns_o_sum;

    always #5 i_clk = ~i_clk;

    ks_sum_stage #(.SAT_EN(1)) u_dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_c0     (i_c0),
        .i_gk     (i_gk),
        .i_p_save (i_p_save),
        .i_sat    (i_sat),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_sum    (o_sum),
        .o_cout   (o_cout),
        .o_ovf    (o_ovf)
    );

    ks_sum_stage #(.SAT_EN(0)) u_dut_nosat (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .o_ready  (ns_o_ready),
        .i_c0     (i_c0),
        .i_gk     (i_gk),
        .i_p_save (i_p_save),
        .i_sat    (i_sat),
        .o_valid  (ns_o_valid),
        .i_ready  (i_ready),
        .o_sum    (ns_o_sum),
        .o_cout   (ns_o_cout),
        .o_ovf    (ns_o_ovf)
    );

    typedef struct {
        logic [15:0] sum_sat;
        logic [15:0] sum_raw;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic c0, input logic sat);
        exp_t        e;
        logic [16:0] full;
        full      = {1'b0, a} + {1'b0, b} + {16'd0, c0};
        e.sum_raw = full[15:0];
        e.cout    = full[16];
        e.ovf     = (a[15] == b[15]) && (full[15] != a[15]);
        e.sum_sat = (sat && e.ovf) ? (a[15] ? 16'h8000 : 16'h7FFF) : e.sum_raw;
        return e;
    endfunction

    // Behavioural prefix: gk[k] is the carry out of bit k including c0.
    task automatic drive_operands(input logic [15:0] a, input logic [15:0] b, input logic c0);
        logic c;
        c = c0;
        for (int k = 0; k < 16; k++) begin
            c       = (a[k] & b[k]) | ((a[k] ^ b[k]) & c);
            i_gk[k] = c;
        end
        i_p_save = a ^ b;
        i_c0     = c0;
    endtask

    // One cycle: drive inputs at the falling edge, check/pop any released word,
    // push the expectation for any accepted word.
    task automatic step(input bit v, input logic [15:0] a, input logic [15:0] b,
                        input bit c0, input bit sat, input bit rdy, input bit chk_lat);
        @(negedge i_clk);
        i_ready = rdy;
        i_valid = v;
        i_sat   = sat;
        if (v) begin
            drive_operands(a, b, c0);
        end else begin
            i_gk     = 16'($urandom);
            i_p_save = 16'($urandom);
            i_c0     = 1'($urandom);
        end
        if (chk_lat) check("latency_valid", {31'd0, o_valid}, 32'd1);
        if (o_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_word", {31'd0, o_valid}, 32'd0);
            end else if (rdy) begin
                exp_t e;
                e = sb.pop_front();
                check("sum",       {16'd0, o_sum},    {16'd0, e.sum_sat});
                check("cout",      {31'd0, o_cout},   {31'd0, e.cout});
                check("ovf",       {31'd0, o_ovf},    {31'd0, e.ovf});
                check("nosat_sum", {16'd0, ns_o_sum}, {16'd0, e.sum_raw});
            end else begin
                check("stall_sum", {16'd0, o_sum}, {16'd0, sb[0].sum_sat});
            end
        end
        if (v && o_ready) sb.push_back(model(a, b, c0, sat));
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("drain_empty", sb.size(), 32'd0);
        @(negedge i_clk);
        check("idle_valid", {31'd0, o_valid}, 32'd0);
    endtask

    initial begin
        int k;
        i_rst_n  = 1'b0;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        i_sat    = 1'b0;
        i_c0     = 1'b0;
        i_gk     = '0;
        i_p_save = '0;

        // Reset values
        @(negedge i_clk);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        check("rst_sum",   {16'd0, o_sum},   32'd0);
        check("rst_cout",  {31'd0, o_cout},  32'd0);
        check("rst_ovf",   {31'd0, o_ovf},   32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Basic add with one-cycle latency
        step(1'b1, 16'h1234, 16'h0FF0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);

        // Carry wrap, both through b and through c0
        step(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);

        // Positive saturation on/off, negative saturation
        step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        drain();

        // Random operands with random handshakes
        for (int i = 0; i < 24; i++)
            step(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'b0);
        drain();

        // Backpressure: 8-word stream, i_ready low for cycles 3..5
        k = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            step(1'b1, 16'h0001 + 16'(k), 16'h0000, 1'b0, 1'b0, !(c >= 3 && c < 6), 1'b0);
            if (c == 3) check("bp_ready_hi",   {31'd0, o_ready}, 32'd1);
            if (c == 4) check("bp_ready_drop", {31'd0, o_ready}, 32'd0);
            if (c == 7) check("bp_ready_back", {31'd0, o_ready}, 32'd1);
            if (o_ready) k++;
        end
        check("bp_all_sent", k, 32'd8);
        drain();

        // Reset while holding two words
        step(1'b1, 16'h0011, 16'h0022, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0033, 16'h0044, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        i_valid = 1'b0;
        check("two_ready", {31'd0, o_ready}, 32'd0);
        i_rst_n = 1'b0;
        #1;
        check("mrst_valid", {31'd0, o_valid}, 32'd0);
        check("mrst_ready", {31'd0, o_ready}, 32'd1);
        check("mrst_sum",   {16'd0, o_sum},   32'd0);
        sb.delete();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step(1'b1, 16'h0100, 16'h0200, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ks_sum_stage.md
# ks_sum_stage

Final, registered stage of the 16-bit Kogge-Stone adder, placed directly after the last prefix stage.
- Consumes the carry-in, the completed group-generate vector and the saved propagate bits.
- Forms the 16-bit sum, carry-out and signed overflow, with optional signed saturation.
- Registers the result behind a 2-entry skid buffer with valid/ready handshakes on both sides, so the FFT butterfly datapath can stall without losing operands.

## Interface
Parameters:
- SAT_EN, default 1: 1 enables the saturation logic; 0 ties saturation off and ignores i_sat.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  reset; asynchronous and active-low.
- i_valid  input  1  upstream word valid.
- o_ready  output  1  stage can accept a word; registered.
- i_c0  input  1  adder carry-in.
- i_gk  input  16  completed prefix generates; i_gk[k] is the carry out of bit k, including c0.
- i_p_save  input  16  bitwise propagate a^b.
- i_sat  input  1  saturate on signed overflow; sampled with the word.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts result.
- o_sum  output  16  result.
- o_cout  output  1  unsigned carry-out.
- o_ovf  output  1  signed overflow of the unsaturated sum.

## Operation
Arithmetic (combinational, evaluated at accept):
- s[0] = p[0] ^ c0.
- s[k] = p[k] ^ gk[k-1] for k = 1..15.
- cout = gk[15].
- ovf = gk[15] ^ gk[14].
- Saturation applies when SAT_EN=1, i_sat=1 and ovf=1:
  - result = 0x8000 if cout=1 (negative overflow);
  - result = 0x7FFF if cout=0 (positive overflow).
- Otherwise result = s.
- o_cout and o_ovf always carry the raw values, whether or not the result was saturated.

Storage: output register OUT (drives o_sum/o_cout/o_ovf) plus skid register SKID. Each holds {sum, cout, ovf}.

Handshake terms:
- acc = i_valid & o_ready.
- rel = o_valid & i_ready.

State machine:
- EMPTY: o_valid=0, o_ready=1.
  - acc: load OUT, go to ONE.
- ONE: o_valid=1, o_ready=1.
  - acc & !rel: load SKID, go to TWO.
  - acc & rel: load OUT, stay in ONE.
  - !acc & rel: go to EMPTY.
  - Neither: hold.
- TWO: o_valid=1, o_ready=0.
  - rel: OUT <= SKID, go to ONE.
  - Otherwise hold.
  - acc cannot occur because o_ready=0.

Rules:
- o_sum, o_cout and o_ovf stay stable while o_valid=1 and i_ready=0.
- Words leave in acceptance order; none is dropped or duplicated.
- o_ready is a registered function of the next state: 1 unless the next state is TWO.
- Inputs are sampled only on acc. While o_ready=0 the upstream stage holds its word; i_gk/i_p_save may toggle freely when i_valid=0.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state = EMPTY, o_valid=0, o_ready=1;
  - o_sum=0x0000, o_cout=0, o_ovf=0;
  - SKID cleared.
- Latency: a word accepted at edge N appears on o_valid/o_sum after edge N, i.e. 1 cycle, when the stage is empty or draining in the same cycle.
- Throughput: 1 word per cycle while i_ready=1.
- One i_ready=0 cycle with continuous input: the stage absorbs exactly one extra word (TWO), and o_ready drops the following cycle.
- In TWO, a rel at edge N re-asserts o_ready after edge N. The next acc is therefore at edge N+1 at the earliest, and there is no combinational ready path.
- Reset asserted mid-operation: contents of OUT and SKID are discarded immediately and outputs take their reset values; no word is emitted.

## Test plan
Bench drives i_gk/i_p_save from a behavioural prefix model of operands a, b, c0.

- Basic add: a=0x1234, b=0x0FF0, c0=0, i_ready=1 -> o_sum=0x2224, o_cout=0, o_ovf=0, o_valid one cycle after acc.
- Carry wrap: a=0xFFFF, b=0x0001, c0=0 -> o_sum=0x0000, o_cout=1, o_ovf=0. Then a=0xFFFF, b=0x0000, c0=1 -> same result.
- Positive saturation: a=0x7FFF, b=0x0001:
  - i_sat=1 -> o_sum=0x7FFF, o_ovf=1, o_cout=0;
  - i_sat=0 -> o_sum=0x8000, o_ovf=1.
- Negative saturation: a=0x8000, b=0x8000, i_sat=1 -> o_sum=0x8000, o_cout=1, o_ovf=1. Repeat with SAT_EN=0 -> o_sum=0x0000.
- Backpressure: stream 0x0001+k (k=0..7) with i_valid=1 and i_ready low for 3 cycles mid-stream:
  - o_ready drops one cycle after the stage holds two words;
  - all 8 results appear in order with no loss;
  - o_sum is stable while stalled.
- Reset mid-stall: state TWO, assert i_rst_n=0 for one cycle -> o_valid=0, o_ready=1 and o_sum=0x0000 immediately; the next accepted word is the first one emitted.
